eth_speed_detect: RTL and testbench

//  Per-channel PHY link-speed detector for 10/100/1000 tri-mode MACs (GMII/MII).

---
 rtl/eth_speed_detect.sv | 152 +++++++++++++++
 tb/tb_eth_speed_detect.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_speed_detect.sv
// eth_speed_detect: per-channel 10/100/1000 link-speed detector for tri-mode MACs.
// Counts edges of a divided rx clock against a fixed window of local clk cycles,
// classifies each window, commits a speed after CONFIRM matching classes, and flags
// channels whose rx clock has stopped.
module eth_speed_detect #(
    parameter int unsigned CHANNELS      = 1,
    parameter int unsigned REF_WIDTH     = 7,
    parameter int unsigned EDGE_WIDTH    = 2,
    parameter int unsigned THRESH_100M   = 32,
    parameter int unsigned CONFIRM       = 2,
    parameter int unsigned NOCLK_WINDOWS = 4,
    parameter int unsigned SYNC_STAGES   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic [CHANNELS-1:0]   rx_prescale_tog,
    output logic [2*CHANNELS-1:0] speed,
    output logic [CHANNELS-1:0]   mii_select,
    output logic [CHANNELS-1:0]   speed_change,
    output logic [CHANNELS-1:0]   clk_lost
);

    localparam int unsigned CandW  = $clog2(CONFIRM + 1);
    localparam int unsigned NoclkW = $clog2(NOCLK_WINDOWS + 1);

    localparam logic [1:0] Speed10   = 2'b00;
    localparam logic [1:0] Speed100  = 2'b01;
    localparam logic [1:0] Speed1000 = 2'b10;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [REF_WIDTH-1:0]   ref_cnt_q, ref_cnt_d;
        logic [EDGE_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
        logic [NoclkW-1:0]      noclk_cnt_q, noclk_cnt_d;
        logic [CandW-1:0]       cand_cnt_q, cand_cnt_d;
        logic [1:0]             cand_q, cand_d;
        logic [1:0]             speed_q, speed_d;
        logic                   mii_q, mii_d;
        logic                   change_q, change_d;
        logic                   lost_q, lost_d;
        logic                   rx_edge, edge_full, ref_ovf, class_vld;
        logic [1:0]             class_val;

        // Synchroniser chain; the async reset on every stage also keeps it out of shift-register
        // primitives.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], rx_prescale_tog[i]};
            end
        end

        assign rx_edge = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];

        // Window events decoded from registered counters; EDGE_FULL takes priority.
        always_comb begin
            edge_full = &edge_cnt_q;
            ref_ovf   = (&ref_cnt_q) & ~edge_full;
            class_vld = edge_full | (ref_ovf & (edge_cnt_q != '0));
            class_val = Speed10;
            if (edge_full) begin
                class_val = (32'(ref_cnt_q) >= THRESH_100M) ? Speed100 : Speed1000;
            end
        end

        // Next state: counters, no-clock tracking, candidate hysteresis and commit.
        always_comb begin
            ref_cnt_d   = ref_cnt_q;
            edge_cnt_d  = edge_cnt_q;
            noclk_cnt_d = noclk_cnt_q;
            cand_d      = cand_q;
            cand_cnt_d  = cand_cnt_q;
            speed_d     = speed_q;
            mii_d       = mii_q;
            change_d    = 1'b0;
            lost_d      = lost_q;
            if (!cfg_enable) begin
                ref_cnt_d   = '0;
                edge_cnt_d  = '0;
                noclk_cnt_d = '0;
                cand_cnt_d  = '0;
            end else begin
                if (edge_full || ref_ovf) begin
                    ref_cnt_d  = '0;
                    edge_cnt_d = '0;
                end else begin
                    ref_cnt_d  = ref_cnt_q + REF_WIDTH'(1);
                    edge_cnt_d = edge_cnt_q + EDGE_WIDTH'(rx_edge);
                end
                // A full window with no edges at all counts towards a lost clock.
                if (ref_ovf && (edge_cnt_q == '0)) begin
                    if (noclk_cnt_q != NoclkW'(NOCLK_WINDOWS)) begin
                        noclk_cnt_d = noclk_cnt_q + NoclkW'(1);
                    end
                    if (noclk_cnt_d == NoclkW'(NOCLK_WINDOWS)) begin
                        lost_d = 1'b1;
                    end
                end
                if (class_vld) begin
                    noclk_cnt_d = '0;
                    lost_d      = 1'b0;
                    if (class_val == cand_q) begin
                        if (cand_cnt_q != CandW'(CONFIRM)) begin
                            cand_cnt_d = cand_cnt_q + CandW'(1);
                        end
                    end else begin
                        cand_d     = class_val;
                        cand_cnt_d = CandW'(1);
                    end
                    if ((cand_cnt_d == CandW'(CONFIRM)) && (cand_d != speed_q)) begin
                        speed_d  = cand_d;
                        mii_d    = (cand_d != Speed1000);
                        change_d = 1'b1;
                    end
                end
            end
        end

        // State registers; speed resets to 1000M with GMII selected.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ref_cnt_q   <= '0;
                edge_cnt_q  <= '0;
                noclk_cnt_q <= '0;
                cand_q      <= Speed10;
                cand_cnt_q  <= '0;
                speed_q     <= Speed1000;
                mii_q       <= 1'b0;
                change_q    <= 1'b0;
                lost_q      <= 1'b0;
            end else begin
                ref_cnt_q   <= ref_cnt_d;
                edge_cnt_q  <= edge_cnt_d;
                noclk_cnt_q <= noclk_cnt_d;
                cand_q      <= cand_d;
                cand_cnt_q  <= cand_cnt_d;
                speed_q     <= speed_d;
                mii_q       <= mii_d;
                change_q    <= change_d;
                lost_q      <= lost_d;
            end
        end

        assign speed[2*i +: 2] = speed_q;
        assign mii_select[i]   = mii_q;
        assign speed_change[i] = change_q;
        assign clk_lost[i]     = lost_q;
    end

endmodule

// File: tb/tb_eth_speed_detect.sv
// Directed bench for eth_speed_detect with two channels and per-channel toggle generators.
module tb_eth_speed_detect;

    logic       clk;
    logic       rst_n;
    logic       cfg_enable;
    logic [1:0] rx_prescale_tog;
    logic [3:0] speed;
    logic [1:0] mii_select;
    logic [1:0] speed_change;
    logic [1:0] clk_lost;

    int n_assert = 0;
    int n_fail   = 0;
    int per[2];
    int gcnt[2];
    int pulses[2];
    int pb0;
    int pb1;
    int lat;

    eth_speed_detect #(
        .CHANNELS     (2),
        .REF_WIDTH    (7),
        .EDGE_WIDTH   (2),
        .THRESH_100M  (32),
        .CONFIRM      (2),
        .NOCLK_WINDOWS(4),
        .SYNC_STAGES  (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_enable     (cfg_enable),
        .rx_prescale_tog(rx_prescale_tog),
        .speed          (speed),
        .mii_select     (mii_select),
        .speed_change   (speed_change),
        .clk_lost       (clk_lost)
    );

    // 125 MHz reference clock.
    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    // Toggle generators: channel c flips every per[c] clk cycles (0 = stopped).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && cfg_enable) begin
                for (int c = 0; c < 2; c++) begin
                    if (per[c] != 0) begin
                        gcnt[c]++;
                        if (gcnt[c] >= per[c]) begin
                            rx_prescale_tog[c] = ~rx_prescale_tog[c];
                            gcnt[c] = 0;
                        end
                    end
                end
            end
        end
    end

    // Counts speed_change pulses per channel.
    initial begin
        pulses[0] = 0;
        pulses[1] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (rst_n && speed_change[c]) pulses[c]++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int got, input int lo, input int hi);
        n_assert++;
        assert (got >= lo && got <= hi) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset the DUT and restart both generators from tog=0; returns on the release negedge.
    task automatic restart(input int p0, input int p1);
        @(negedge clk);
        rst_n = 1'b0;
        cfg_enable = 1'b0;
        rx_prescale_tog = 2'b00;
        gcnt[0] = 0;
        gcnt[1] = 0;
        per[0] = p0;
        per[1] = p1;
        cyc(2);
        rst_n = 1'b1;
        cfg_enable = 1'b1;
    endtask

    // Cycles from now until speed of channel ch reads val (limit on timeout).
    task automatic wait_speed(input int ch, input logic [1:0] val, input int limit,
                              output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (speed[2*ch +: 2] === val) break;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_enable = 1'b0;
        rx_prescale_tog = 2'b00;
        per[0] = 0;
        per[1] = 0;
        gcnt[0] = 0;
        gcnt[1] = 0;

        // Reset values.
        cyc(3);
        check("rst_speed", 32'(speed), 32'h0000_000a);
        check("rst_mii", 32'(mii_select), 32'h0);
        check("rst_change", 32'(speed_change), 32'h0);
        check("rst_lost", 32'(clk_lost), 32'h0);

        // 1000M on both channels: class 10 matches reset speed, nothing commits.
        per[0] = 4;
        per[1] = 4;
        rst_n = 1'b1;
        cfg_enable = 1'b1;
        cyc(400);
        check("g_speed", 32'(speed), 32'h0000_000a);
        check("g_mii", 32'(mii_select), 32'h0);
        check("g_lost", 32'(clk_lost), 32'h0);
        check("g_pulses", 32'(pulses[0] + pulses[1]), 32'h0);

        // 100M: second EDGE_FULL at cycle 124 commits speed 01.
        pb0 = pulses[0];
        pb1 = pulses[1];
        restart(20, 20);
        wait_speed(0, 2'b01, 400, lat);
        check_rng("m_latency", lat, 122, 126);
        check("m_change_hi", 32'(speed_change), 32'h3);
        check("m_speed", 32'(speed), 32'h0000_0005);
        check("m_mii", 32'(mii_select), 32'h3);
        cyc(1);
        check("m_change_lo", 32'(speed_change), 32'h0);
        cyc(3);
        check("m_pulses0", 32'(pulses[0] - pb0), 32'h1);
        check("m_pulses1", 32'(pulses[1] - pb1), 32'h1);

        // Asynchronous reset mid-window (ref_cnt about 60), away from any clock edge.
        cyc(56);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_speed", 32'(speed), 32'h0000_000a);
        check("ar_mii", 32'(mii_select), 32'h0);
        check("ar_change", 32'(speed_change), 32'h0);
        check("ar_lost", 32'(clk_lost), 32'h0);
        restart(20, 20);
        wait_speed(0, 2'b01, 400, lat);
        check_rng("ar_relatency", lat, 122, 126);

        // Glitch: one fast window on ch0, then back to 100M; hysteresis blocks any commit.
        per[0] = 4;
        gcnt[0] = 0;
        cyc(13);
        per[0] = 20;
        gcnt[0] = 0;
        pb0 = pulses[0];
        cyc(500);
        check("gl_speed0", 32'(speed[1:0]), 32'h1);
        check("gl_pulses0", 32'(pulses[0] - pb0), 32'h0);

        // 10M on ch0: class 00 at ref overflow of windows ending 256 and 512.
        pb0 = pulses[0];
        restart(200, 20);
        wait_speed(0, 2'b00, 700, lat);
        check_rng("t_latency", lat, 510, 514);
        check("t_mii", 32'(mii_select), 32'h3);
        check("t_speed1", 32'(speed[3:2]), 32'h1);
        check("t_lost", 32'(clk_lost), 32'h0);
        cyc(3);
        check("t_pulses0", 32'(pulses[0] - pb0), 32'h1);

        // Clock loss on ch1: four empty windows needed; speed held, ch0 unaffected.
        per[1] = 0;
        cyc(350);
        check("cl_early", 32'(clk_lost), 32'h0);
        cyc(350);
        check("cl_lost", 32'(clk_lost), 32'h2);
        check("cl_speed", 32'(speed), 32'h0000_0004);
        check("cl_mii", 32'(mii_select), 32'h3);

        // Disable holds clk_lost and speed.
        cfg_enable = 1'b0;
        cyc(300);
        check("dis_lost", 32'(clk_lost), 32'h2);
        check("dis_speed", 32'(speed), 32'h0000_0004);
        check("dis_change", 32'(speed_change), 32'h0);

        // Clock returns: first class event clears clk_lost.
        cfg_enable = 1'b1;
        per[1] = 20;
        gcnt[1] = 0;
        cyc(250);
        check("rec_lost", 32'(clk_lost), 32'h0);

        // Counters held clear while disabled: a stopped clock never raises clk_lost.
        per[1] = 0;
        cyc(2);
        cfg_enable = 1'b0;
        pb0 = pulses[0];
        pb1 = pulses[1];
        cyc(800);
        check("hold_lost", 32'(clk_lost), 32'h0);
        check("hold_pulses", 32'((pulses[0] - pb0) + (pulses[1] - pb1)), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
